latch_bank_ctrl: RTL and testbench

- Write sequencer and 2-requester arbiter for a bank of N reversible gated SR latches (Fredkin-gate latch cells: inputs en/s/r, outputs q/qb).
- Sits between two clocked requesters and the latch bank.
- Serialises each set/reset request into a safe SETUP → PULSE → HOLD → CHECK sequence.
- Guarantees s and r are never both high; at most one latch enable is active at a time.
- Reads back q/qb and reports completion or error per request.

---
 rtl/latch_ctrl_pkg.sv | 7 +
 rtl/rr_arb2.sv | 15 +
 rtl/latch_bank_ctrl.sv | 97 +++++++++
 tb/tb_latch_bank_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: shared state encoding and constants for the latch bank write sequencer
package latch_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK, ACK, ERR_ACK} state_e;
  localparam logic SET = 1'b1;
  localparam logic RST = 1'b0;
  localparam int CHECK_CYC = 3;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; pointer favours the requester not granted last
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  assign gnt_o[0] = en_i & req_i[0] & (~ptr_q | ~req_i[1]);
  assign gnt_o[1] = en_i & req_i[1] & (ptr_q | ~req_i[0]);
  assign ptr_d = (|gnt_o) ? gnt_o[0] : ptr_q;
  // pointer moves to the other requester after every grant
  always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: arbitrates two requesters and sequences safe set/reset writes into a latch bank
module latch_bank_ctrl import latch_ctrl_pkg::*; #(
  parameter int N  = 8,
  parameter int AW = 3,
  parameter int PW = 2,
  parameter int HC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          val0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          val1,
  output logic          ack1,
  output logic          err1,
  output logic          busy,
  output logic [N-1:0]  en,
  output logic [N-1:0]  s,
  output logic [N-1:0]  r,
  input  logic [N-1:0]  q,
  input  logic [N-1:0]  qb
);
  localparam int CW = 8;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a_q, a_sel;
  logic          v_q, v_sel, g_q, err_q, err_d, drive, ack_st;
  logic [1:0]    gnt;
  logic [N-1:0]  q_s1_q, q_s2_q, qb_s1_q, qb_s2_q, oh;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == IDLE),
    .req_i ({req1 & ~ack1, req0 & ~ack0}),
    .gnt_o (gnt)
  );

  assign a_sel = gnt[1] ? addr1 : addr0;
  assign v_sel = gnt[1] ? val1 : val0;
  assign err_d = (q_s2_q[a_q] != v_q) || (q_s2_q[a_q] == qb_s2_q[a_q]);

  // next state; the cycle counter restarts on every state change
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|gnt) state_d = (32'(a_sel) >= N) ? ERR_ACK : SETUP;
      SETUP:   state_d = PULSE;
      PULSE:   if (cnt_q == CW'(PW - 1)) state_d = HOLD;
      HOLD:    if (cnt_q == CW'(HC - 1)) state_d = CHECK;
      CHECK:   if (cnt_q == CW'(CHECK_CYC - 1)) state_d = ACK;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // state, captured request and readback verdict taken on the last CHECK cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      v_q     <= 1'b0;
      g_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (|gnt) begin
        a_q <= a_sel;
        v_q <= v_sel;
        g_q <= gnt[1];
      end
      if (state_q == CHECK && state_d == ACK) err_q <= err_d;
    end
  end

  // two-flop synchroniser for the unclocked latch outputs
  always_ff @(posedge clk)
    {q_s2_q, q_s1_q, qb_s2_q, qb_s1_q} <= rst ? '0 : {q_s1_q, q, qb_s1_q, qb};

  assign oh     = {{(N-1){1'b0}}, 1'b1} << a_q;
  assign drive  = state_q inside {SETUP, PULSE, HOLD};
  assign en     = (state_q == PULSE) ? oh : '0;
  assign s      = (drive && v_q == SET) ? oh : '0;
  assign r      = (drive && v_q == RST) ? oh : '0;
  assign ack_st = state_q inside {ACK, ERR_ACK};
  assign ack0   = ack_st & ~g_q;
  assign ack1   = ack_st & g_q;
  assign err0   = ack0 & ((state_q == ERR_ACK) | err_q);
  assign err1   = ack1 & ((state_q == ERR_ACK) | err_q);
  assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: directed checks of the latch bank sequencer against a behavioural latch model
module tb_latch_bank_ctrl;
  localparam int N  = 6;
  localparam int AW = 3;
  logic          clk = 1'b0, rst = 1'b1;
  logic          req0 = 1'b0, val0 = 1'b0, req1 = 1'b0, val1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          ack0, err0, ack1, err1, busy;
  logic [N-1:0]  en, s, r, q, qb;
  logic [N-1:0]  lq = '0, fq0 = '0, fboth = '0;
  int            checks = 0, errors = 0;
  int            lat;
  bit            drv;

  always #5 clk = ~clk;

  latch_bank_ctrl #(.N(N), .AW(AW), .PW(2), .HC(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .val0(val0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .val1(val1), .ack1(ack1), .err1(err1),
    .busy(busy), .en(en), .s(s), .r(r), .q(q), .qb(qb)
  );

  // gated SR cells: enabled cell follows s/r; fq0 pins q low, fboth drives q = qb = 1
  always @(posedge clk)
    for (int i = 0; i < N; i++) if (en[i] && (s[i] || r[i])) lq[i] <= s[i];
  assign q  = (lq & ~fq0) | fboth;
  assign qb = ~(lq & ~fq0) | fboth;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bank safety invariants every cycle out of reset
  always @(negedge clk)
    if (!rst) chk("invariant", {60'd0, |(s & r), !$onehot0(en), |(en & ~(s | r)), ack0 & ack1}, 64'd0);

  task automatic wait_ack(input bit w, output int l, output bit d);
    l = 0;
    d = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      d |= |(en | s | r);
      if (w ? ack1 : ack0) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic txn(input string tag, input bit w, input logic [AW-1:0] a, input bit v,
                     input bit ee, input int el);
    int l;
    bit d;
    if (w) begin req1 = 1'b1; addr1 = a; val1 = v; end
    else begin req0 = 1'b1; addr0 = a; val0 = v; end
    wait_ack(w, l, d);
    chk({tag, "_lat"}, 64'(l), 64'(el));
    chk({tag, "_err"}, 64'(w ? err1 : err0), 64'(ee));
    chk({tag, "_drv"}, 64'(d), 64'(el != 1));
    if (w) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_drive", 64'({en, s, r}), 64'd0);
    chk("rst_status", 64'({busy, ack0, ack1, err0, err1}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    // simultaneous pair from reset: requester 0 first, requester 1 nine cycles later
    req0 = 1'b1; addr0 = 3'd2; val0 = 1'b1;
    req1 = 1'b1; addr1 = 3'd3; val1 = 1'b0;
    wait_ack(1'b0, lat, drv);
    chk("cont_ack0_lat", 64'(lat), 64'd8);
    chk("cont_err0", 64'(err0), 64'd0);
    chk("cont_ack1_low", 64'(ack1), 64'd0);
    req0 = 1'b0;
    wait_ack(1'b1, lat, drv);
    chk("cont_ack1_lat", 64'(lat), 64'd9);
    chk("cont_err1", 64'(err1), 64'd0);
    req1 = 1'b0;
    @(negedge clk);
    chk("cont_q", 64'({q[3], qb[3], q[2], qb[2]}), 64'b0110);
    // single set of cell 5, cycle by cycle
    req0 = 1'b1; addr0 = 3'd5; val0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("set_en_c%0d", k), 64'(en), 64'((k == 2 || k == 3) ? 6'b100000 : 6'b0));
      chk($sformatf("set_s_c%0d", k), 64'(s), 64'((k <= 4) ? 6'b100000 : 6'b0));
      chk($sformatf("set_r_c%0d", k), 64'(r), 64'd0);
      chk($sformatf("set_busy_c%0d", k), 64'(busy), 64'd1);
      chk($sformatf("set_ack0_c%0d", k), 64'(ack0), 64'(k == 8));
    end
    chk("set_err0", 64'(err0), 64'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("set_q5", 64'({q[5], qb[5]}), 64'b10);
    chk("set_idle", 64'(busy), 64'd0);
    // last grant went to requester 0, so requester 1 wins this pair
    req0 = 1'b1; addr0 = 3'd0; val0 = 1'b1;
    req1 = 1'b1; addr1 = 3'd1; val1 = 1'b1;
    wait_ack(1'b1, lat, drv);
    chk("pair_ack1_lat", 64'(lat), 64'd8);
    chk("pair_err1", 64'(err1), 64'd0);
    chk("pair_ack0_low", 64'(ack0), 64'd0);
    req1 = 1'b0;
    wait_ack(1'b0, lat, drv);
    chk("pair_ack0_lat", 64'(lat), 64'd9);
    chk("pair_err0", 64'(err0), 64'd0);
    req0 = 1'b0;
    @(negedge clk);
    // stuck-at-0 cell and illegal q == qb pair
    fq0 = 6'b010000;
    txn("stuck4", 1'b0, 3'd4, 1'b1, 1'b1, 8);
    fq0 = '0;
    fboth = 6'b000010;
    txn("illegal_v0", 1'b1, 3'd1, 1'b0, 1'b1, 8);
    txn("illegal_v1", 1'b1, 3'd1, 1'b1, 1'b1, 8);
    fboth = '0;
    // out-of-range addresses ack right after the grant cycle without driving cells
    txn("oor7", 1'b1, 3'd7, 1'b1, 1'b1, 1);
    txn("oor6", 1'b0, 3'd6, 1'b0, 1'b1, 1);
    // reset while en[0] is pulsing
    req0 = 1'b1; addr0 = 3'd0; val0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rp_en", 64'(en), 64'b000001);
    rst = 1'b1;
    @(negedge clk);
    chk("rp_drive", 64'({en, s, r}), 64'd0);
    chk("rp_status", 64'({busy, ack0, ack1}), 64'd0);
    req0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rp_noack", 64'({busy, ack0}), 64'd0);
    txn("reissue", 1'b0, 3'd0, 1'b0, 1'b0, 8);
    chk("reissue_q0", 64'({q[0], qb[0]}), 64'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
